// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - switch sync/debounce, one-hot play validation and play timeout
module detector_jogada #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 3000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       limpa,
    input  logic [3:0] chaves,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       jogada_invalida,
    output logic       timeout,
    output logic       db_tem_jogada,
    output logic [1:0] db_estado
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] OCIOSO        = 2'b00;
    localparam logic [1:0] FILTRANDO     = 2'b01;
    localparam logic [1:0] ESPERA_SOLTAR = 2'b10;

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);

    logic [3:0]    s1, s2, cand;
    logic [1:0]    estado;
    logic [DW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic          one_hot, aceita, contando;

    always_comb begin
        one_hot  = (cand != 4'd0) && ((cand & (cand - 4'd1)) == 4'd0);
        aceita   = (estado == FILTRANDO) && (s2 == cand) && (cnt == DB_LAST);
        contando = (estado == OCIOSO) || (estado == FILTRANDO);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 4'd0;
            s2 <= 4'd0;
        end else begin
            s1 <= chaves;
            s2 <= s1;
        end
    end

    // cnt is shared: press-stability count in FILTRANDO, release count in ESPERA_SOLTAR
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
            cand   <= 4'd0;
            cnt    <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (s2 != 4'd0) begin
                        cand   <= s2;
                        cnt    <= DW'(1);
                        estado <= FILTRANDO;
                    end
                end
                FILTRANDO: begin
                    if (s2 == 4'd0) begin
                        estado <= OCIOSO;
                        cnt    <= '0;
                    end else if (s2 != cand) begin
                        cand <= s2;
                        cnt  <= DW'(1);
                    end else if (cnt == DB_LAST) begin
                        estado <= ESPERA_SOLTAR;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + DW'(1);
                    end
                end
                ESPERA_SOLTAR: begin
                    if (s2 != 4'd0) begin
                        cnt <= '0;
                    end else if (cnt == DB_LAST) begin
                        estado <= OCIOSO;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + DW'(1);
                    end
                end
                default: begin
                    estado <= OCIOSO;
                    cnt    <= '0;
                end
            endcase
        end
    end

    // an accepted valid play overrides a same-cycle limpa
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            jogada          <= 4'd0;
            jogada_feita    <= 1'b0;
            jogada_invalida <= 1'b0;
        end else begin
            jogada_feita    <= aceita && enable && one_hot;
            jogada_invalida <= aceita && enable && !one_hot;
            if (aceita && enable && one_hot) begin
                jogada <= cand;
            end else if (limpa) begin
                jogada <= 4'd0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            if (!enable || limpa || aceita) begin
                tcnt <= '0;
            end else if (contando && (tcnt != TO_MAX)) begin
                tcnt <= tcnt + TW'(1);
            end

            if (!enable || limpa) begin
                timeout <= 1'b0;
            end else if (!aceita && contando && (tcnt == TO_LAST)) begin
                timeout <= 1'b1;
            end
        end
    end

    assign db_tem_jogada = |s2;
    assign db_estado     = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// tb/tb_detector_jogada.sv - directed vector bench for detector_jogada
module tb_detector_jogada;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       limpa;
    logic [3:0] chaves;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       jogada_invalida;
    logic       timeout;
    logic       db_tem_jogada;
    logic [1:0] db_estado;

    int n_vec  = 0;
    int n_miss = 0;
    int nf, ni;

    detector_jogada dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .limpa           (limpa),
        .chaves          (chaves),
        .jogada          (jogada),
        .jogada_feita    (jogada_feita),
        .jogada_invalida (jogada_invalida),
        .timeout         (timeout),
        .db_tem_jogada   (db_tem_jogada),
        .db_estado       (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] ch;
        logic       en;
        int         hold;
        logic [3:0] exp_j;
        int         exp_f;
        int         exp_i;
    } vec_t;

    vec_t tab[8];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_count(input int n);
        repeat (n) begin
            tick();
            nf += int'(jogada_feita);
            ni += int'(jogada_invalida);
        end
    endtask

    initial begin
        tab[0] = '{4'b0001, 1'b1, 10, 4'b0001, 1, 0};
        tab[1] = '{4'b0100, 1'b1,  3, 4'b0001, 0, 0};
        tab[2] = '{4'b1000, 1'b1,  5, 4'b1000, 1, 0};
        tab[3] = '{4'b0011, 1'b1, 10, 4'b1000, 0, 1};
        tab[4] = '{4'b0010, 1'b1,  4, 4'b0010, 1, 0};
        tab[5] = '{4'b0100, 1'b0, 10, 4'b0010, 0, 0};
        tab[6] = '{4'b1111, 1'b1, 10, 4'b0010, 0, 1};
        tab[7] = '{4'b0100, 1'b1,  6, 4'b0100, 1, 0};

        reset  = 1'b1;
        enable = 1'b0;
        limpa  = 1'b0;
        chaves = 4'd0;

        // reset is asynchronous: outputs must clear before any edge
        #2 reset = 1'b0;
        #1;
        chk("rst jogada", int'(jogada), 0);
        chk("rst feita", int'(jogada_feita), 0);
        chk("rst invalida", int'(jogada_invalida), 0);
        chk("rst timeout", int'(timeout), 0);
        chk("rst tem_jogada", int'(db_tem_jogada), 0);
        chk("rst estado", int'(db_estado), 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // valid press latency: pulse after edge 6, release back to idle after edge 6
        enable = 1'b1;
        chaves = 4'b0001;
        tick();
        chk("B tem_jogada e1", int'(db_tem_jogada), 0);
        tick();
        chk("B tem_jogada e2", int'(db_tem_jogada), 1);
        repeat (3) tick();
        chk("B feita e5", int'(jogada_feita), 0);
        tick();
        chk("B feita e6", int'(jogada_feita), 1);
        chk("B jogada e6", int'(jogada), 1);
        chk("B estado e6", int'(db_estado), 2);
        tick();
        chk("B feita e7", int'(jogada_feita), 0);
        nf = 0;
        ni = 0;
        tick_count(3);
        chaves = 4'd0;
        tick_count(5);
        chk("B estado rel5", int'(db_estado), 2);
        tick_count(1);
        chk("B estado rel6", int'(db_estado), 0);
        chk("B no second pulse", nf, 0);

        // reset mid-debounce
        chaves = 4'b0010;
        repeat (4) tick();
        #2 reset = 1'b0;
        #1;
        chk("midrst jogada", int'(jogada), 0);
        chk("midrst estado", int'(db_estado), 0);
        chk("midrst tem_jogada", int'(db_tem_jogada), 0);
        chaves = 4'd0;
        tick();
        reset = 1'b1;
        repeat (2) tick();

        for (int v = 0; v < 8; v++) begin
            nf = 0;
            ni = 0;
            enable = tab[v].en;
            chaves = tab[v].ch;
            tick_count(tab[v].hold);
            chaves = 4'd0;
            tick_count(8);
            enable = 1'b1;
            chk($sformatf("v%0d jogada", v), int'(jogada), int'(tab[v].exp_j));
            chk($sformatf("v%0d feita", v), nf, tab[v].exp_f);
            chk($sformatf("v%0d invalida", v), ni, tab[v].exp_i);
            chk($sformatf("v%0d estado", v), int'(db_estado), 0);
        end

        // timeout expiry after edge 3000, then limpa clears it
        enable = 1'b0;
        tick();
        enable = 1'b1;
        repeat (2999) tick();
        chk("T timeout e2999", int'(timeout), 0);
        tick();
        chk("T timeout e3000", int'(timeout), 1);
        limpa = 1'b1;
        tick();
        limpa = 1'b0;
        chk("T limpa timeout", int'(timeout), 0);
        chk("T limpa jogada", int'(jogada), 0);

        // play accepted on edge 3000 beats the timeout
        enable = 1'b0;
        tick();
        enable = 1'b1;
        repeat (2994) tick();
        chaves = 4'b0001;
        repeat (5) tick();
        chk("TP feita e2999", int'(jogada_feita), 0);
        tick();
        chk("TP feita e3000", int'(jogada_feita), 1);
        chk("TP timeout e3000", int'(timeout), 0);
        repeat (3) tick();
        chk("TP timeout after", int'(timeout), 0);
        chaves = 4'd0;
        repeat (8) tick();

        // limpa on the acceptance edge: the play still loads
        chaves = 4'b0100;
        repeat (5) tick();
        limpa = 1'b1;
        tick();
        limpa = 1'b0;
        chk("LA jogada", int'(jogada), 4);
        chk("LA feita", int'(jogada_feita), 1);
        chaves = 4'd0;
        repeat (8) tick();

        // limpa while the switch is still held: no re-report
        chaves = 4'b0010;
        repeat (6) tick();
        chk("LH jogada accept", int'(jogada), 2);
        repeat (2) tick();
        limpa = 1'b1;
        tick();
        limpa = 1'b0;
        chk("LH jogada cleared", int'(jogada), 0);
        chk("LH estado held", int'(db_estado), 2);
        nf = 0;
        ni = 0;
        tick_count(5);
        chaves = 4'd0;
        tick_count(8);
        chk("LH no repulse", nf, 0);
        chk("LH estado released", int'(db_estado), 0);
        chaves = 4'b0010;
        tick_count(10);
        chaves = 4'd0;
        tick_count(8);
        chk("LH repress pulse", nf, 1);
        chk("LH repress jogada", int'(jogada), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/detector_jogada.md
# detector_jogada

Input-conditioning stage placed between the player's switches (`chaves`) and the `circuito_exp5` game datapath/FSM. It does four things:
- synchronizes and debounces the 4-bit switch bank;
- validates that exactly one switch is pressed and registers that value as the play (`jogada`);
- emits a single-cycle `jogada_feita` pulse per press;
- runs the per-play timeout counter that drives the game FSM's timeout transition.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a press or a release (minimum 2).
- `TIMEOUT_CYCLES`, default 3000: enabled idle cycles before `timeout` asserts (minimum 2).

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: play window open (driven by the game FSM).
- `limpa` in 1: synchronous clear of `jogada`, the timeout counter and `timeout`.
- `chaves` in 4: raw asynchronous switch inputs.
- `jogada` out 4: last accepted one-hot play.
- `jogada_feita` out 1: one-cycle pulse on an accepted valid play.
- `jogada_invalida` out 1: one-cycle pulse on an accepted press that is not one-hot.
- `timeout` out 1: level; the play window expired.
- `db_tem_jogada` out 1: synchronized `chaves` is nonzero.
- `db_estado` out 2: FSM state code.

## Operation
Synchronizer:
- Two-flop synchronizer on `chaves`, producing `s2`.
- All decisions use `s2` only.

FSM states:
- OCIOSO (00): waiting for a press.
- FILTRANDO (01): a candidate value is being debounced.
- ESPERA_SOLTAR (10): a press was accepted; waiting for release.

OCIOSO:
- If `s2 != 0`: `cand <= s2`, `cnt <= 1`, go to FILTRANDO.

FILTRANDO:
- If `s2 == cand`: `cnt` increments.
- When `cnt` reaches `DEBOUNCE_CYCLES`, the press is accepted and the FSM goes to ESPERA_SOLTAR:
  - If `cand` is one-hot and `enable = 1`: `jogada <= cand`, pulse `jogada_feita`.
  - If `cand` is not one-hot and `enable = 1`: pulse `jogada_invalida`; `jogada` is unchanged.
  - If `enable = 0`: no pulse of either kind.
- If `s2 == 0`: the glitch is discarded and the FSM returns to OCIOSO.
- If `s2` is some other nonzero value: `cand <= s2`, `cnt <= 1`.

ESPERA_SOLTAR:
- Requires `s2 == 0` for `DEBOUNCE_CYCLES` consecutive cycles, then returns to OCIOSO.
- Any nonzero sample restarts the release count.
- No pulses are ever issued in this state: exactly one pulse per physical press.

Timeout:
- Counter increments each cycle while `enable = 1` and the state is OCIOSO or FILTRANDO.
- Cleared by `enable = 0`, `limpa`, or the acceptance of any press.
- `timeout` asserts on the cycle the count reaches `TIMEOUT_CYCLES`; the counter saturates there.
- `timeout` holds high until `limpa` or until `enable` falls.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`; the debounce counter is `$clog2(DEBOUNCE_CYCLES+1)`.

`limpa`:
- Does not change FSM state, so a switch still held is never re-reported.

Simultaneous events:
- Acceptance on the same cycle as timeout expiry: the play wins and `timeout` stays 0.
- `limpa` and acceptance on the same cycle: `jogada` loads `cand`.

`db_tem_jogada` equals `|s2`.

## Timing
Reset (asynchronous, `reset = 0`):
- `jogada = 0000`, `jogada_feita = 0`, `jogada_invalida = 0`, `timeout = 0`, `db_tem_jogada = 0`, `db_estado = 00`.
- Synchronizer flops, `cand` and both counters are 0.
- Reset asserted mid-operation aborts any debounce or timeout in progress.
- Release is synchronous to the next rising edge.

Press latency:
- Number the first edge that samples a new stable `chaves` value as edge 1.
- `jogada_feita`/`jogada_invalida` and the new `jogada` become visible after edge `DEBOUNCE_CYCLES + 2`.
- Pulses are exactly one cycle wide.
- Minimum accepted press is `DEBOUNCE_CYCLES` cycles; with the default of 4, a 5-cycle press is accepted and a 3-cycle press is rejected.

Timeout latency:
- With `enable` rising before edge 1, `timeout` goes high after edge `TIMEOUT_CYCLES`.

All outputs are registered.

## Test plan
- Reset check: assert `reset = 0` mid-run → all outputs 0 and `db_estado = 00` immediately, before any clock edge.
- Valid press: `enable = 1`, `chaves = 0001` held 10 cycles, then 0000 → `jogada_feita` high for one cycle after edge 6, `jogada = 0001`, FSM returns to OCIOSO 6 cycles after release; no second pulse.
- Short presses: `chaves = 0100` held 3 cycles → no pulse, `jogada` unchanged. `chaves = 1000` held 5 cycles → accepted, `jogada = 1000`.
- Invalid press: `chaves = 0011` held 10 cycles → `jogada_invalida` one-cycle pulse, `jogada_feita = 0`, `jogada` unchanged.
- Timeout: `enable = 1`, no press for 3000 cycles → `timeout = 1` after edge 3000. A press accepted on edge 3000 → `timeout` stays 0. `limpa` → `timeout = 0`, `jogada = 0000`.
- `limpa` while held: `limpa` pulsed while 0010 is held in ESPERA_SOLTAR → `jogada = 0000` and no new `jogada_feita`. Release, then press 0010 again → pulse and `jogada = 0010`.
